// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and defaults for the unified memory arbiter
package memory_arbiter_pkg;

   localparam int DEFAULT_WORD_SIZE = 32;

   typedef enum logic {
      ARB,
      FORCE_I
   } arb_state_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_I,
      GRANT_D
   } grant_t;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of consecutive denied fetch cycles
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_next;

   always_comb begin
      w_next = r_count;
      if (clr)
         w_next = '0;
      else if (inc && (r_count != LIMIT))
         w_next = r_count + CW'(1);
   end

   // Looks at the next value so the FSM can force fetch on the very next cycle.
   assign at_limit = (w_next == LIMIT);

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else
         r_count <= w_next;
   end

endmodule

// File: rtl/unified_memory_arbiter.sv
// rtl/unified_memory_arbiter.sv - fetch/data arbiter in front of one single-port memory
import memory_arbiter_pkg::*;

module unified_memory_arbiter #(
   parameter int BIT_COUNT    = 32,
   parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
   parameter int STARVE_LIMIT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   IReq,
   input  logic [BIT_COUNT-1:0]   IAdr,
   output logic                   IReady,
   output logic                   IRespValid,
   output logic [WORD_SIZE-1:0]   IRespData,
   input  logic                   DReq,
   input  logic                   DWrite,
   input  logic [WORD_SIZE/8-1:0] DByteEn,
   input  logic [BIT_COUNT-1:0]   DAdr,
   input  logic [WORD_SIZE-1:0]   DWriteData,
   output logic                   DReady,
   output logic                   DRespValid,
   output logic [WORD_SIZE-1:0]   DRespData,
   output logic                   MemEn,
   output logic                   MemWrite,
   output logic [WORD_SIZE/8-1:0] ByteEn,
   output logic [BIT_COUNT-1:0]   MemAdr,
   output logic [WORD_SIZE-1:0]   MemWriteData,
   input  logic [WORD_SIZE-1:0]   MemReadData
);

   arb_state_t           r_state;
   grant_t               w_grant;
   logic                 w_at_limit;
   logic                 r_i_valid;
   logic                 r_d_valid;
   logic [WORD_SIZE-1:0] r_i_data;
   logic [WORD_SIZE-1:0] r_d_data;

   always_comb begin
      w_grant = GRANT_NONE;
      if (!reset) begin
         if (IReq && DReq)
            w_grant = (r_state == FORCE_I) ? GRANT_I : GRANT_D;
         else if (IReq)
            w_grant = GRANT_I;
         else if (DReq)
            w_grant = GRANT_D;
      end
   end

   assign IReady = (w_grant == GRANT_I);
   assign DReady = (w_grant == GRANT_D);

   always_comb begin
      MemEn        = 1'b0;
      MemWrite     = 1'b0;
      ByteEn       = '0;
      MemAdr       = '0;
      MemWriteData = '0;
      case (w_grant)
         GRANT_I: begin
            MemEn  = 1'b1;
            MemAdr = IAdr;
         end
         GRANT_D: begin
            MemEn        = 1'b1;
            MemWrite     = DWrite;
            ByteEn       = DByteEn;
            MemAdr       = DAdr;
            MemWriteData = DWriteData;
         end
         default: ;
      endcase
   end

   arb_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (IReq && !IReady),
      .clr      (!IReq || IReady),
      .at_limit (w_at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ARB;
      else if (w_at_limit)
         r_state <= FORCE_I;
      else if ((r_state == FORCE_I) && (IReady || !IReq))
         r_state <= ARB;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;
         r_i_data  <= '0;
         r_d_data  <= '0;
      end else begin
         r_i_valid <= IReady;
         r_d_valid <= DReady;
         if (IReady)
            r_i_data <= MemReadData;
         if (DReady)
            r_d_data <= DWrite ? '0 : MemReadData;
      end
   end

   // Responses are masked while reset is high so one captured the cycle before is dropped.
   assign IRespValid = r_i_valid && !reset;
   assign DRespValid = r_d_valid && !reset;
   assign IRespData  = reset ? '0 : r_i_data;
   assign DRespData  = reset ? '0 : r_d_data;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb/tb_unified_memory_arbiter.sv - directed self-checking bench for unified_memory_arbiter
module tb_unified_memory_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        IReq;
   logic [31:0] IAdr;
   logic        IReady;
   logic        IRespValid;
   logic [31:0] IRespData;
   logic        DReq;
   logic        DWrite;
   logic [3:0]  DByteEn;
   logic [31:0] DAdr;
   logic [31:0] DWriteData;
   logic        DReady;
   logic        DRespValid;
   logic [31:0] DRespData;
   logic        MemEn;
   logic        MemWrite;
   logic [3:0]  ByteEn;
   logic [31:0] MemAdr;
   logic [31:0] MemWriteData;
   logic [31:0] MemReadData;

   logic [31:0] mem [0:63];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   unified_memory_arbiter #(
      .BIT_COUNT    (32),
      .WORD_SIZE    (32),
      .STARVE_LIMIT (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .IReq         (IReq),
      .IAdr         (IAdr),
      .IReady       (IReady),
      .IRespValid   (IRespValid),
      .IRespData    (IRespData),
      .DReq         (DReq),
      .DWrite       (DWrite),
      .DByteEn      (DByteEn),
      .DAdr         (DAdr),
      .DWriteData   (DWriteData),
      .DReady       (DReady),
      .DRespValid   (DRespValid),
      .DRespData    (DRespData),
      .MemEn        (MemEn),
      .MemWrite     (MemWrite),
      .ByteEn       (ByteEn),
      .MemAdr       (MemAdr),
      .MemWriteData (MemWriteData),
      .MemReadData  (MemReadData)
   );

   // Stand-in single-port storage: combinational read, byte-lane write on the edge.
   assign MemReadData = mem[MemAdr[7:2]];

   always @(posedge clk) begin
      if (MemEn && MemWrite)
         for (int b = 0; b < 4; b++)
            if (ByteEn[b])
               mem[MemAdr[7:2]][8*b +: 8] <= MemWriteData[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic d_issue(input logic wr, input logic [3:0] be, input logic [31:0] adr,
                          input logic [31:0] data);
      DReq       = 1'b1;
      DWrite     = wr;
      DByteEn    = be;
      DAdr       = adr;
      DWriteData = data;
      settle();
      check("d_ready", {31'd0, DReady}, 32'd1);
      step();
   endtask

   logic [1:0]  exp_g [0:5];
   logic        prev_i;

   initial begin
      exp_g = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
      reset = 1'b1;
      IReq = 1'b1; IAdr = 32'h8;
      DReq = 1'b1; DWrite = 1'b0; DByteEn = 4'h0; DAdr = 32'h40; DWriteData = 32'h0;

      repeat (2) begin
         settle();
         check("rst_ready", {30'd0, IReady, DReady}, 32'd0);
         check("rst_memen", {31'd0, MemEn}, 32'd0);
         check("rst_resp",  {30'd0, IRespValid, DRespValid}, 32'd0);
         step();
      end
      reset = 1'b0; IReq = 1'b0; DReq = 1'b0;

      // Seed the instruction word through the data port.
      DReq = 1'b1; DWrite = 1'b1; DByteEn = 4'hF; DAdr = 32'h8; DWriteData = 32'h00500093;
      settle();
      check("st_ready",  {31'd0, DReady}, 32'd1);
      check("st_memwr",  {27'd0, MemWrite, ByteEn}, 32'h1F);
      check("st_wdata",  MemWriteData, 32'h00500093);
      step();
      DReq = 1'b0;
      settle();
      check("st_ack_v",  {31'd0, DRespValid}, 32'd1);
      check("st_ack_d",  DRespData, 32'd0);
      check("idle_memen", {31'd0, MemEn}, 32'd0);
      step();

      IReq = 1'b1; IAdr = 32'h8;
      settle();
      check("if_ready",  {31'd0, IReady}, 32'd1);
      check("if_adr",    MemAdr, 32'h8);
      check("if_wr_be",  {27'd0, MemWrite, ByteEn}, 32'd0);
      step();
      IReq = 1'b0;
      settle();
      check("if_rvalid", {31'd0, IRespValid}, 32'd1);
      check("if_rdata",  IRespData, 32'h00500093);
      step();

      d_issue(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
      DWrite = 1'b0;
      settle();
      check("b2b_ack_v", {31'd0, DRespValid}, 32'd1);
      check("b2b_ack_d", DRespData, 32'd0);
      check("b2b_ready", {31'd0, DReady}, 32'd1);
      step();
      DReq = 1'b0;
      settle();
      check("raw_v",     {31'd0, DRespValid}, 32'd1);
      check("raw_d",     DRespData, 32'hDEADBEEF);
      step();

      d_issue(1'b1, 4'hF, 32'h50, 32'h11223344);
      d_issue(1'b1, 4'h1, 32'h50, 32'h000000AB);
      d_issue(1'b0, 4'h0, 32'h50, 32'h0);
      DReq = 1'b0;
      settle();
      check("part_v",    {31'd0, DRespValid}, 32'd1);
      check("part_d",    DRespData, 32'h112233AB);
      step();

      IReq = 1'b1; IAdr = 32'h8;
      DReq = 1'b1; DWrite = 1'b0; DAdr = 32'h40;
      prev_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         settle();
         check($sformatf("cont_g%0d", i), {30'd0, IReady, DReady}, {30'd0, exp_g[i]});
         check($sformatf("cont_a%0d", i), MemAdr, exp_g[i][1] ? 32'h8 : 32'h40);
         check($sformatf("cont_r%0d", i), {31'd0, IRespValid}, {31'd0, prev_i});
         prev_i = exp_g[i][1];
         step();
      end

      // Two more data wins arm FORCE_I; reset then lands on the pending response.
      repeat (2) begin
         settle();
         check("pre_rst_g", {30'd0, IReady, DReady}, 32'd1);
         step();
      end
      reset = 1'b1;
      settle();
      check("mid_rst_dv", {31'd0, DRespValid}, 32'd0);
      check("mid_rst_rdy", {30'd0, IReady, DReady}, 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("post_rst_g%0d", i), {30'd0, IReady, DReady},
               (i == 2) ? 32'd2 : 32'd1);
         step();
      end
      IReq = 1'b0;
      settle();
      check("tail_d_rdy", {31'd0, DReady}, 32'd1);
      check("tail_i_v",   {31'd0, IRespValid}, 32'd1);
      check("tail_i_d",   IRespData, 32'h00500093);
      step();
      DReq = 1'b0;
      settle();
      check("tail_d_v",   {31'd0, DRespValid}, 32'd1);
      check("tail_d_d",   DRespData, 32'hDEADBEEF);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
